// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Grants one operation at a time (IDLE -> EXEC -> RESP), registers the
// operands toward the ALU, captures its result one cycle later and holds
// the response until it is taken. Priority toggles to the other requester
// after each completed response, so contention alternates fairly.
module alu_arbiter #(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_ctrl,
  input  logic [2:0]  req1_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  // Flag layout {OverFlow, Carry, Zero, Negative}; an illegal op reports Zero only.
  localparam logic [3:0] ERR_FLAGS  = 4'b0010;
  localparam logic       PRIO_RESET = 1'(RESET_PRIO);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_ctrl_q, alu_ctrl_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_err_q, rsp_err_d;

  logic grant0, grant1, ctrl_legal;

  // Winner of the current IDLE cycle: a lone requester always wins, a tie goes to prio.
  assign grant0     = req0_valid && (!req1_valid || !prio_q);
  assign grant1     = req1_valid && (!req0_valid ||  prio_q);
  assign ctrl_legal = alu_ctrl_q inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101};

  // State and datapath registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      prio_q       <= PRIO_RESET;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next-state, datapath updates and request handshake.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    state_d      = state_q;
    prio_d       = prio_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Readies are gated by reset so nothing is accepted while in reset.
        req0_ready = rst && grant0;
        req1_ready = rst && grant1;
        if (grant0 || grant1) begin
          alu_a_d    = grant1 ? req1_a    : req0_a;
          alu_b_d    = grant1 ? req1_b    : req0_b;
          alu_ctrl_d = grant1 ? req1_ctrl : req0_ctrl;
          rsp_id_d   = grant1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_err_d    = !ctrl_legal;
        rsp_result_d = ctrl_legal ? alu_result : '0;
        rsp_flags_d  = ctrl_legal ? alu_flags  : ERR_FLAGS;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          prio_d      = !rsp_id_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small combinational ALU model.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.RESET_PRIO(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_ctrl  (req0_ctrl),
    .req1_ctrl  (req1_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Shared ALU model: add, sub, and, or, slt; anything else returns junk
  // so the arbiter's illegal-code override is visible.
  always_comb begin
    logic [32:0] t;
    t          = '0;
    alu_result = 32'hDEAD_BEEF;
    alu_flags  = 4'hF;
    case (alu_ctrl)
      3'b000: begin
        t          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = t[31:0];
        alu_flags  = {(alu_a[31] == alu_b[31]) && (t[31] != alu_a[31]), t[32], t[31:0] == 0, t[31]};
      end
      3'b001: begin
        t          = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = t[31:0];
        alu_flags  = {(alu_a[31] != alu_b[31]) && (t[31] != alu_a[31]), !t[32], t[31:0] == 0, t[31]};
      end
      3'b010: begin
        alu_result = alu_a & alu_b;
        alu_flags  = {2'b00, alu_result == 0, alu_result[31]};
      end
      3'b011: begin
        alu_result = alu_a | alu_b;
        alu_flags  = {2'b00, alu_result == 0, alu_result[31]};
      end
      3'b101: begin
        alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
        alu_flags  = {2'b00, alu_result == 0, 1'b0};
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;

    // Reset values, readies held low despite pending requests.
    tick(); tick(); #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flags", rsp_flags, 0);

    // req0 alone: 5 - 3.
    tick();
    rst = 1'b1; req1_valid = 1'b0;
    req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b001;
    #1;
    check("sub_c0_ready0", req0_ready, 1);
    check("sub_c0_ready1", req1_ready, 0);
    tick(); req0_valid = 1'b0; #1;
    check("sub_c1_busy", busy, 1);
    check("sub_c1_alu_a", alu_a, 5);
    check("sub_c1_alu_b", alu_b, 3);
    check("sub_c1_alu_ctrl", alu_ctrl, 3'b001);
    check("sub_c1_rsp_valid", rsp_valid, 0);
    tick();
    check("sub_c2_rsp_valid", rsp_valid, 1);
    check("sub_c2_rsp_id", rsp_id, 0);
    check("sub_c2_result", rsp_result, 2);
    check("sub_c2_flags", rsp_flags, 4'b0100);
    check("sub_c2_err", rsp_err, 0);
    tick();
    check("sub_c3_rsp_valid", rsp_valid, 0);
    check("sub_c3_busy", busy, 0);
    check("sub_c3_alu_a_hold", alu_a, 5);

    // Fresh reset, then both requesters contend continuously.
    rst = 1'b0; tick(); tick();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 3'b000;
    req1_a = 32'd6; req1_b = 32'd3; req1_ctrl = 3'b010;
    for (int c = 0; c < 12; c++) begin
      if (c == 10) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      check($sformatf("rr_c%0d_ready0", c), req0_ready, (c % 3 == 0) && ((c / 3) % 2 == 0));
      check($sformatf("rr_c%0d_ready1", c), req1_ready, (c % 3 == 0) && ((c / 3) % 2 == 1));
      if (c % 3 == 2) begin
        check($sformatf("rr_c%0d_rsp_id", c), rsp_id, (c / 3) % 2);
        check($sformatf("rr_c%0d_result", c), rsp_result, ((c / 3) % 2) ? 32'd2 : 32'd2);
        check($sformatf("rr_c%0d_flags", c), rsp_flags, 4'b0000);
      end
      tick();
    end
    check("rr_end_busy", busy, 0);

    // Illegal control code from req1: result and flags overridden.
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_ctrl = 3'b110;
    #1;
    check("ill_c0_ready1", req1_ready, 1);
    tick(); req1_valid = 1'b0; tick();
    check("ill_c2_rsp_valid", rsp_valid, 1);
    check("ill_c2_rsp_id", rsp_id, 1);
    check("ill_c2_err", rsp_err, 1);
    check("ill_c2_result", rsp_result, 0);
    check("ill_c2_flags", rsp_flags, 4'b0010);
    tick();

    // Backpressure: response held five cycles while req1 waits.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h10; req0_b = 32'h20; req0_ctrl = 3'b011;
    #1;
    check("bp_c0_ready0", req0_ready, 1);
    tick(); req0_valid = 1'b0; req1_valid = 1'b1; req1_ctrl = 3'b000; tick();
    for (int c = 2; c < 7; c++) begin
      check($sformatf("bp_c%0d_rsp_valid", c), rsp_valid, 1);
      check($sformatf("bp_c%0d_result", c), rsp_result, 32'h30);
      check($sformatf("bp_c%0d_id", c), rsp_id, 0);
      check($sformatf("bp_c%0d_flags", c), rsp_flags, 4'b0000);
      check($sformatf("bp_c%0d_ready1", c), req1_ready, 0);
      check($sformatf("bp_c%0d_busy", c), busy, 1);
      tick();
    end
    rsp_ready = 1'b1; #1;
    check("bp_c7_rsp_valid", rsp_valid, 1);
    tick();
    check("bp_c8_rsp_valid", rsp_valid, 0);
    check("bp_c8_busy", busy, 0);
    check("bp_c8_ready1", req1_ready, 1);
    req1_valid = 1'b0;
    tick();

    // Reset while holding a response: aborted, prio back to RESET_PRIO.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h55; req0_b = 32'd1; req0_ctrl = 3'b000;
    tick(); req0_valid = 1'b0; tick();
    check("ab_c2_rsp_valid", rsp_valid, 1);
    rst = 1'b0; req1_valid = 1'b1; #1;
    check("ab_rst_ready1", req1_ready, 0);
    tick();
    check("ab_rsp_valid", rsp_valid, 0);
    check("ab_busy", busy, 0);
    check("ab_alu_a", alu_a, 0);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; #1;
    check("ab_prio_ready0", req0_ready, 1);
    check("ab_prio_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // Lone req0 granted twice in a row: signed overflow add.
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_ctrl = 3'b000;
    #1;
    check("b2b_c0_ready0", req0_ready, 1);
    tick();
    check("b2b_c1_alu_a", alu_a, 32'h7FFF_FFFF);
    check("b2b_c1_alu_b", alu_b, 1);
    check("b2b_c1_ready0", req0_ready, 0);
    tick();
    check("b2b_c2_result", rsp_result, 32'h8000_0000);
    check("b2b_c2_flags", rsp_flags, 4'b1001);
    check("b2b_c2_id", rsp_id, 0);
    tick();
    check("b2b_c3_ready0", req0_ready, 1);
    tick(); req0_valid = 1'b0; #1;
    check("b2b_c4_busy", busy, 1);
    check("b2b_c4_alu_a", alu_a, 32'h7FFF_FFFF);
    tick();
    check("b2b_c5_result", rsp_result, 32'h8000_0000);
    check("b2b_c5_flags", rsp_flags, 4'b1001);
    tick();
    check("b2b_c6_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
